wb_timer: RTL and testbench

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_if.sv | 27 ++
 rtl/wb_timer.sv | 186 ++++++++++++++++++
 tb/tb_wb_timer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_if.sv
// rtl/wb_if.sv - Wishbone classic bus bundle with master and slave views
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone-mapped down-counting timer with prescaler and interrupt
module wb_timer #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rstn,
  wb_if.slave  s,
  output logic irq
);

  if (WB_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("wb_timer: WB_DATA_WIDTH must be 32");
  end

  if (WB_ADDR_WIDTH < 5) begin : g_bad_addr_width
    $error("wb_timer: WB_ADDR_WIDTH must cover ADR[4:2]");
  end

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_STATUS   = 3'd1;
  localparam logic [2:0] A_LOAD     = 3'd2;
  localparam logic [2:0] A_COUNT    = 3'd3;
  localparam logic [2:0] A_PRESCALE = 3'd4;

  state_t      state;
  logic        ack_q, err_q;
  logic [31:0] dat_r_q;
  logic        irq_q;

  logic        ctrl_en, ctrl_auto_reload, ctrl_irq_en;
  logic        status_expired;
  logic [31:0] load_q, count_q;
  logic [15:0] prescale_q, pc_q;

  // Burst signalling and undecoded address bits have no effect on this slave.
  logic unused_bits;
  assign unused_bits = ^{s.cti, s.bte, s.adr};

  logic [2:0] reg_idx;
  logic       addr_bad, accept, wr;
  logic       wr_ctrl, wr_status, wr_load, wr_count, wr_prescale;

  assign reg_idx     = s.adr[4:2];
  assign addr_bad    = (reg_idx > A_PRESCALE);
  assign accept      = (state == IDLE) && s.cyc && s.stb;
  assign wr          = accept && s.we && !addr_bad;
  assign wr_ctrl     = wr && (reg_idx == A_CTRL) && s.sel[0];
  assign wr_status   = wr && (reg_idx == A_STATUS) && s.sel[0];
  assign wr_load     = wr && (reg_idx == A_LOAD);
  assign wr_count    = wr && (reg_idx == A_COUNT);
  assign wr_prescale = wr && (reg_idx == A_PRESCALE);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [31:0] rd_data;

  // Register read mux, sampled into dat_r when a beat is accepted.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      A_CTRL:     rd_data = {29'd0, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
      A_STATUS:   rd_data = {31'd0, status_expired};
      A_LOAD:     rd_data = load_q;
      A_COUNT:    rd_data = count_q;
      A_PRESCALE: rd_data = {16'd0, prescale_q};
      default:    rd_data = '0;
    endcase
  end

  logic        tick, fire;
  logic        nxt_en, nxt_auto, nxt_ie, nxt_exp;
  logic [31:0] nxt_load, nxt_count;
  logic [15:0] nxt_pre, nxt_pc;

  // Timer progression first, then bus writes layered on top with their priorities.
  always_comb begin
    tick      = ctrl_en && (pc_q >= prescale_q);
    fire      = tick && (count_q == 32'd0);
    nxt_en    = ctrl_en;
    nxt_auto  = ctrl_auto_reload;
    nxt_ie    = ctrl_irq_en;
    nxt_exp   = status_expired;
    nxt_load  = load_q;
    nxt_count = count_q;
    nxt_pre   = prescale_q;
    nxt_pc    = pc_q;

    if (ctrl_en) nxt_pc = tick ? 16'd0 : pc_q + 16'd1;

    if (tick) begin
      if (count_q != 32'd0) begin
        nxt_count = count_q - 32'd1;
      end else begin
        nxt_exp = 1'b1;
        if (ctrl_auto_reload) nxt_count = load_q;
        else                  nxt_en    = 1'b0;
      end
    end

    if (wr_ctrl) begin
      nxt_en   = s.dat_w[0];
      nxt_auto = s.dat_w[1];
      nxt_ie   = s.dat_w[2];
      if (s.dat_w[0] && !ctrl_en) nxt_pc = 16'd0;
    end
    // A same-cycle expiry wins over the W1C clear so no expiry is ever lost.
    if (wr_status && s.dat_w[0] && !fire) nxt_exp = 1'b0;
    if (wr_load)  nxt_load  = byte_merge(load_q, s.dat_w, s.sel);
    if (wr_count) nxt_count = byte_merge(count_q, s.dat_w, s.sel);
    if (wr_prescale) begin
      nxt_pre = {s.sel[1] ? s.dat_w[15:8] : prescale_q[15:8],
                 s.sel[0] ? s.dat_w[7:0]  : prescale_q[7:0]};
    end
  end

  // Timer and register state; irq is re-registered from the next-state values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_en          <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      status_expired   <= 1'b0;
      load_q           <= '0;
      count_q          <= '0;
      prescale_q       <= '0;
      pc_q             <= '0;
      irq_q            <= 1'b0;
    end else begin
      ctrl_en          <= nxt_en;
      ctrl_auto_reload <= nxt_auto;
      ctrl_irq_en      <= nxt_ie;
      status_expired   <= nxt_exp;
      load_q           <= nxt_load;
      count_q          <= nxt_count;
      prescale_q       <= nxt_pre;
      pc_q             <= nxt_pc;
      irq_q            <= nxt_exp & nxt_ie;
    end
  end

  // Two-state bus FSM: accept in IDLE, respond for exactly one cycle in RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.cyc && s.stb) begin
            state   <= RESP;
            ack_q   <= !addr_bad;
            err_q   <= addr_bad;
            dat_r_q <= addr_bad ? 32'd0 : rd_data;
          end
        end
        RESP: begin
          state   <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          dat_r_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.ack   = ack_q;
  assign s.err   = err_q;
  assign s.dat_r = dat_r_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - self-checking bench for wb_timer
module tb_wb_timer;

  logic clk = 1'b0;
  logic rstn;
  logic irq;

  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  wb_timer #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (wb),
    .irq  (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the timer's architectural state.
  bit          m_en, m_auto, m_ie, m_exp;
  logic [31:0] m_load, m_count;
  int          m_pre, m_pc;
  bit          m_acc, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic [31:0] exp_rdata;
  bit          exp_err;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_step();
    bit          tick, fire;
    int          slot;
    bit          n_en, n_auto, n_ie, n_exp;
    logic [31:0] n_load, n_count, tmp;
    int          n_pre, n_pc;
    tick    = m_en && (m_pc >= m_pre);
    fire    = tick && (m_count == 0);
    n_en    = m_en && !(fire && !m_auto);
    n_auto  = m_auto;
    n_ie    = m_ie;
    n_exp   = m_exp || fire;
    n_load  = m_load;
    n_pre   = m_pre;
    n_pc    = !m_en ? m_pc : (tick ? 0 : m_pc + 1);
    n_count = m_count;
    if (tick) n_count = (m_count != 0) ? m_count - 1 : (m_auto ? m_load : 32'd0);
    if (m_acc) begin
      slot = int'(m_adr[4:2]);
      exp_err <= (slot > 4);
      if      (slot == 0) exp_rdata <= {29'd0, m_ie, m_auto, m_en};
      else if (slot == 1) exp_rdata <= {31'd0, m_exp};
      else if (slot == 2) exp_rdata <= m_load;
      else if (slot == 3) exp_rdata <= m_count;
      else if (slot == 4) exp_rdata <= 32'(m_pre);
      else                exp_rdata <= 32'd0;
      if (m_we && slot <= 4) begin
        if (slot == 0 && m_sel[0]) begin
          if (m_dat[0] && !m_en) n_pc = 0;
          n_en   = m_dat[0];
          n_auto = m_dat[1];
          n_ie   = m_dat[2];
        end
        if (slot == 1 && m_sel[0] && m_dat[0] && !fire) n_exp = 0;
        if (slot == 2) n_load  = merge_bytes(m_load, m_dat, m_sel);
        if (slot == 3) n_count = merge_bytes(m_count, m_dat, m_sel);
        if (slot == 4) begin
          tmp   = merge_bytes(32'(m_pre), m_dat, m_sel);
          n_pre = int'(tmp[15:0]);
        end
      end
    end
    m_en <= n_en; m_auto <= n_auto; m_ie <= n_ie; m_exp <= n_exp;
    m_load <= n_load; m_count <= n_count; m_pre <= n_pre; m_pc <= n_pc;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_en <= 0; m_auto <= 0; m_ie <= 0; m_exp <= 0;
      m_load <= 0; m_count <= 0; m_pre <= 0; m_pc <= 0;
      exp_rdata <= 0; exp_err <= 0;
    end else begin
      model_step();
    end
  end

  // Every cycle, timer state and irq must track the model.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("cyc_irq", irq, m_exp & m_ie);
      chk("cyc_count", dut.count_q, m_count);
      chk("cyc_expired", dut.status_expired, m_exp);
      chk("cyc_en", dut.ctrl_en, m_en);
    end
  end

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output logic got_err);
    wb.adr = adr; wb.dat_w = dat; wb.sel = sel; wb.we = we;
    wb.cyc = 1'b1; wb.stb = 1'b1;
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we; m_acc = 1'b1;
    @(posedge clk); #1;
    m_acc = 1'b0;
    wb.cyc = 1'b0; wb.stb = 1'b0;
    rdata   = wb.dat_r;
    got_err = wb.err;
    chk("bus_ack", wb.ack, !exp_err);
    chk("bus_err", wb.err, exp_err);
    if (!we) chk("bus_rdata", wb.dat_r, exp_rdata);
    @(posedge clk); #1;
    chk("idle_ack_err", {wb.ack, wb.err}, 2'b00);
    chk("idle_dat_r", wb.dat_r, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] r;
    logic        e;
    wb_access(1'b1, adr, dat, 4'hF, r, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    wb_access(1'b0, adr, 32'd0, 4'hF, r, e);
    chk(name, r, exp);
  endtask

  // Leaves the bench one edge before a prescaler tick (optionally one that expires).
  task automatic wait_tick_edge(input bit need_zero);
    int guard;
    guard = 0;
    while (!(m_en && m_pc >= m_pre && (!need_zero || m_count == 0)) && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wait_tick_timeout", 32'(guard < 64), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] adr, dat;
    int          slot;

    rstn = 1'b0;
    wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.adr = 0; wb.dat_w = 0; wb.sel = 0;
    wb.cti = 0; wb.bte = 0;
    m_acc = 0; m_we = 0; m_adr = 0; m_dat = 0; m_sel = 0;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h3, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'h0000_CCDD, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0018, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h0000_001C, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'h0000_CCDD, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hC, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'hFFFF_FF0B, 32'h0,         4'hF, 32'h1122_CCDD, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0010, 32'hFFFF_0005, 4'hF, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h0000_0005, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFA, 4'hE, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[17] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFA, 4'h1, 32'h0,         1'b0};
    vecs[18] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0000_0002, 1'b0};
    vecs[19] = '{1'b1, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[20] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_err", {wb.ack, wb.err}, 2'b00);
    chk("rst_dat_r", wb.dat_r, 32'd0);
    chk("rst_irq", irq, 1'b0);
    rstn = 1'b1;

    // Reset values, byte enables, error window, address aliasing.
    for (int i = 0; i < NV; i++) begin
      wb_access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r, e);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
    end

    // One-shot with PRESCALE=0: one tick per cycle from the edge after enabling.
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'd3);
    wr(32'h10, 32'd0);
    wr(32'h00, 32'h5);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("os_count_k%0d", k), dut.count_q, (k < 3) ? 32'(3 - k) : 32'd0);
      chk($sformatf("os_expired_k%0d", k), dut.status_expired, 32'(k >= 4));
      chk($sformatf("os_irq_k%0d", k), irq, 32'(k >= 4));
      chk($sformatf("os_en_k%0d", k), dut.ctrl_en, 32'(k < 4));
      @(posedge clk); #1;
    end
    rd_chk("os_ctrl", 32'h00, 32'h4);
    rd_chk("os_status", 32'h04, 32'h1);
    rd_chk("os_count_hold", 32'h0C, 32'h0);
    wr(32'h04, 32'h1);
    rd_chk("os_status_w1c", 32'h04, 32'h0);
    chk("os_irq_cleared", irq, 1'b0);

    // Auto-reload, tick every 3 cycles, expiry every second tick, no irq.
    wr(32'h10, 32'd2);
    wr(32'h08, 32'd1);
    wr(32'h0C, 32'd1);
    wr(32'h00, 32'h3);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("ar_count_k%0d", k), dut.count_q, ((k / 3) % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("ar_expired_k%0d", k), dut.status_expired, 32'((k / 3) >= 2));
      chk($sformatf("ar_irq_k%0d", k), irq, 1'b0);
      @(posedge clk); #1;
    end

    // COUNT write coinciding with a tick.
    wr(32'h0C, 32'h100);
    wr(32'h10, 32'd3);
    wr(32'h00, 32'h1);
    wait_tick_edge(1'b0);
    wr(32'h0C, 32'h10);
    rd_chk("col_count_write", 32'h0C, 32'h10);

    // W1C coinciding with an expiry.
    wr(32'h00, 32'h3);
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wait_tick_edge(1'b1);
    wr(32'h04, 32'h1);
    rd_chk("col_status_w1c", 32'h04, 32'h1);

    // EN write coinciding with a one-shot expiry that would clear EN.
    wr(32'h0C, 32'd2);
    wr(32'h00, 32'h1);
    wait_tick_edge(1'b1);
    wr(32'h00, 32'h1);
    rd_chk("col_ctrl_en", 32'h00, 32'h1);
    rd_chk("col_expired", 32'h04, 32'h1);

    // Reset while a response is being driven.
    wr(32'h10, 32'd100);
    wr(32'h0C, 32'd5);
    wr(32'h00, 32'h1);
    wb.adr = 32'h0C; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
    m_adr = 32'h0C; m_we = 1'b0; m_sel = 4'hF; m_acc = 1'b1;
    @(posedge clk); #1;
    m_acc = 1'b0;
    chk("mid_ack_before_rst", wb.ack, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_ack", wb.ack, 1'b0);
    chk("mid_err", wb.err, 1'b0);
    chk("mid_dat_r", wb.dat_r, 32'd0);
    chk("mid_irq", irq, 1'b0);
    chk("mid_count", dut.count_q, 32'd0);
    chk("mid_load", dut.load_q, 32'd0);
    chk("mid_prescale", dut.prescale_q, 32'd0);
    chk("mid_pc", dut.pc_q, 32'd0);
    chk("mid_ctrl", {dut.ctrl_irq_en, dut.ctrl_auto_reload, dut.ctrl_en}, 3'b000);
    chk("mid_status", dut.status_expired, 1'b0);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", {wb.ack, wb.err}, 2'b00);
    end
    rd_chk("post_rst_count", 32'h0C, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      slot = $urandom_range(0, 7);
      adr  = ($urandom & 32'hFFFF_FFE3) | (32'(slot) << 2);
      dat  = $urandom;
      if ($urandom_range(0, 3) != 0) dat = dat & 32'h7;
      wb.cti = 3'($urandom);
      wb.bte = 2'($urandom);
      wb_access(1'($urandom_range(0, 1)), adr, dat, 4'($urandom_range(0, 15)), r, e);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
